// File: rtl/parallel_to_serial_tx.sv
// rtl/parallel_to_serial_tx.sv - LSB-first parallel-to-serial transmitter with frame markers; optional even parity via P2S_PARITY_EN
module parallel_to_serial_tx #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out,
   output logic             out_valid,
   output logic             out_first,
   output logic             out_last,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
`ifdef P2S_PARITY_EN
   localparam int FL = WIDTH + 1;
   localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
`else
   localparam int FL = WIDTH;
`endif
   localparam logic [CW-1:0] LAST_CNT = CW'(FL - 1);
   localparam logic [CW-1:0] PRE_LAST = CW'(FL - 2);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic             out_first_q, out_first_d;
   logic             out_last_q, out_last_d;
`ifdef P2S_PARITY_EN
   logic             par_q, par_d;
`endif
   logic             accept;

   // Ready while idle or while the last bit of the current frame is on the wire
   assign in_ready = !rst && ((state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST_CNT)));
   assign accept   = in_valid && in_ready;

   // Next-state: load on accept, otherwise advance one bit per cycle; cnt tracks the bit being shown
   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      cnt_d       = cnt_q;
      out_d       = 1'b0;
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
`ifdef P2S_PARITY_EN
      par_d       = par_q;
`endif
      if (accept) begin
         state_d     = SHIFT;
         sreg_d      = in_data;
         cnt_d       = '0;
         out_d       = in_data[0];
         out_valid_d = 1'b1;
         out_first_d = 1'b1;
`ifdef P2S_PARITY_EN
         par_d       = in_data[0];
`endif
      end else if (state_q == SHIFT) begin
         if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            // rotate rather than zero-fill so the word is intact again after a data pass
            sreg_d      = {sreg_q[0], sreg_q[WIDTH-1:1]};
            cnt_d       = cnt_q + CNT_ONE;
            out_valid_d = 1'b1;
            out_last_d  = (cnt_q == PRE_LAST);
`ifdef P2S_PARITY_EN
            if (cnt_q == DATA_LAST) begin
               out_d = par_q;
            end else begin
               out_d = sreg_q[1];
               par_d = par_q ^ sreg_q[1];
            end
`else
            out_d = sreg_q[1];
`endif
         end
      end
   end

   // State and registered outputs; reset wins over any accept on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         cnt_q       <= '0;
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         out_last_q  <= 1'b0;
`ifdef P2S_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_first_q <= out_first_d;
         out_last_q  <= out_last_d;
`ifdef P2S_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign out_first = out_first_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// tb/tb_parallel_to_serial_tx.sv - randomized and directed bench for parallel_to_serial_tx at WIDTH 8 and 16
module tb_parallel_to_serial_tx;

   localparam int W0 = 8;
   localparam int W1 = 16;
`ifdef P2S_PARITY_EN
   localparam int PX = 1;
`else
   localparam int PX = 0;
`endif

   typedef struct packed {
      logic b;
      logic f;
      logic l;
   } ent_t;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        iv    = 1'b0;
   logic [31:0] idata = '0;
   int          sel   = 0;

   logic v0, v1;
   logic r0, o0, ov0, f0, l0, b0;
   logic r1, o1, ov1, f1, l1, b1;
   logic m_rdy, m_out, m_ov, m_f, m_l, m_b;

   assign v0 = iv && (sel == 0);
   assign v1 = iv && (sel == 1);

   assign m_rdy = (sel == 1) ? r1  : r0;
   assign m_out = (sel == 1) ? o1  : o0;
   assign m_ov  = (sel == 1) ? ov1 : ov0;
   assign m_f   = (sel == 1) ? f1  : f0;
   assign m_l   = (sel == 1) ? l1  : l0;
   assign m_b   = (sel == 1) ? b1  : b0;

   parallel_to_serial_tx #(.WIDTH(W0)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_data(idata[W0-1:0]), .in_ready(r0),
      .out(o0), .out_valid(ov0), .out_first(f0), .out_last(l0), .busy(b0)
   );

   parallel_to_serial_tx #(.WIDTH(W1)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_data(idata[W1-1:0]), .in_ready(r1),
      .out(o1), .out_valid(ov1), .out_first(f1), .out_last(l1), .busy(b1)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   ent_t        pend[$];
   ent_t        cur;
   logic        cur_v = 1'b0;
   logic [31:0] sent[$];
   logic [31:0] rx_word = '0;
   int          rx_idx = 0;
   int          rx_frames = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, predict the edge from the frame model, then check outputs
   task automatic step(input logic r, input logic v, input logic [31:0] d);
      int          w;
      int          fl;
      logic [31:0] dm;
      logic        exp_rdy;
      logic        acc;
      logic [31:0] exp_w;
      ent_t        e;
      w  = (sel == 1) ? W1 : W0;
      fl = w + PX;
      dm = d & ((32'd1 << w) - 32'd1);
      rst   = r;
      iv    = v;
      idata = d;
      #1;
      exp_rdy = !r && (pend.size() == 0);
      check_eq("in_ready", 32'(m_rdy), 32'(exp_rdy));
      acc = v && exp_rdy;
      @(posedge clk);
      if (r) begin
         pend.delete();
         sent.delete();
         cur_v  = 1'b0;
         rx_idx = 0;
      end else begin
         if (acc) begin
            for (int j = 0; j < fl; j++) begin
               e.b = (j < w) ? dm[j] : ^dm;
               e.f = (j == 0);
               e.l = (j == fl - 1);
               pend.push_back(e);
            end
            sent.push_back(dm);
         end
         if (pend.size() > 0) begin
            cur   = pend.pop_front();
            cur_v = 1'b1;
         end else begin
            cur_v = 1'b0;
         end
      end
      @(negedge clk);
      check_eq("out_valid", 32'(m_ov), 32'(cur_v));
      check_eq("out",       32'(m_out), 32'(cur_v && cur.b));
      check_eq("out_first", 32'(m_f), 32'(cur_v && cur.f));
      check_eq("out_last",  32'(m_l), 32'(cur_v && cur.l));
      check_eq("busy",      32'(m_b), 32'(cur_v));
      // independent LSB-first receiver fed from the serial outputs
      if (m_ov) begin
         if (m_f) begin
            rx_word = '0;
            rx_idx  = 0;
         end
         if (rx_idx < w) rx_word[rx_idx] = m_out;
         else check_eq("rx_parity", 32'(m_out), 32'(^rx_word));
         rx_idx++;
         if (m_l) begin
            exp_w = (sent.size() > 0) ? sent.pop_front() : 32'hDEAD_BEEF;
            check_eq("rx_word", rx_word, exp_w);
            rx_frames++;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      sel = 0;
      idle(2);

      step(1'b0, 1'b1, 32'hA5);
      idle(W0 + PX + 2);
      check_eq("a5_rx", rx_word, 32'hA5);

      step(1'b0, 1'b1, 32'h01);
      repeat (W0 + PX) step(1'b0, 1'b1, 32'h80);
      idle(W0 + PX + 2);
      check_eq("b2b_rx", rx_word, 32'h80);

      step(1'b0, 1'b1, 32'h07);
      idle(W0 + PX + 1);
      step(1'b0, 1'b1, 32'h03);
      idle(W0 + PX + 1);

      step(1'b0, 1'b1, 32'hFF);
      idle(3);
      step(1'b1, 1'b0, 32'h0);
      idle(1);
      step(1'b0, 1'b1, 32'h0F);
      idle(W0 + PX + 2);
      check_eq("after_rst_rx", rx_word, 32'h0F);

      step(1'b0, 1'b1, 32'hC3);
      idle(2);
      step(1'b0, 1'b1, 32'h55);
      idle(W0 + PX + 2);
      check_eq("ignored_rx", rx_word, 32'hC3);

      for (int s = 0; s < 2; s++) begin
         sel = s;
         idle(2);
         rx_frames = 0;
         for (int c = 0; c < 30000 && rx_frames < 500; c++)
            step(1'b0, $urandom_range(0, 3) != 0, $urandom);
         idle(W1 + PX + 2);
         check_eq("loop_frames", 32'(rx_frames >= 500), 32'h1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
